// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared types and constants for the OV7670 SCCB configuration writer.
//   sccb_state_t : top-level sequencer states
//   *_Q          : number of quarter-bit periods spent in each bus phase
//   SCCB_BITS    : bits per 3-phase write (3 x (8 data + 1 don't-care))
//   max_int      : elaboration-time helper for derived wait lengths
// ---------------------------------------------------------------------------
package ov7670_pkg;

  typedef enum logic [2:0] {
    WAIT,
    LOAD,
    START,
    BIT,
    STOP,
    DONE
  } sccb_state_t;

  localparam int SCCB_BITS = 27;
  localparam int START_Q   = 2;
  localparam int BIT_Q     = 4;
  localparam int STOP_Q    = 3;

  localparam logic [15:0] SOFT_RESET_CMD = 16'h1280;
  localparam logic [15:0] END_CMD        = 16'hFFFF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sccb_quarter_timer.sv
// ---------------------------------------------------------------------------
// sccb_quarter_timer
// Free-running divider that marks the last clk cycle of every quarter SCCB
// bit period.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   i_restart : synchronous restart; the cycle after it is count 0
//   o_tick    : high during the last cycle of each CLK_DIV-cycle quarter
// ---------------------------------------------------------------------------
module sccb_quarter_timer #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_count;
  logic          r_tick;

  // The tick is kept as a register that mirrors (r_count == LAST), so the
  // sequencer sees a clean flop output rather than a comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (i_restart || (r_count == LAST)) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= r_count + 1'b1;
      r_tick  <= ((r_count + 1'b1) == LAST);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/ov7670_sccb_sender.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_sender
// SCCB 3-phase write master. Out of reset it waits, then repeatedly samples
// the command source, writes {DEV_ADDR, reg, value} to the camera and steps
// the source with a one-cycle advance pulse, until the source reports
// finished.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   command     : [15:8] register address, [7:0] value
//   finished    : command source exhausted
//   advance     : 1-cycle pulse stepping the command source
//   sioc        : SCCB clock
//   siod_o      : SCCB data value
//   siod_oe     : SCCB data drive enable (0 = released, don't-care bit)
//   busy        : transaction in progress, START through STOP
//   config_done : sticky once finished has been sampled
// ---------------------------------------------------------------------------
module ov7670_sccb_sender
  import ov7670_pkg::*;
#(
  parameter int         CLK_DIV      = 250,
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         STARTUP_WAIT = 1000,
  parameter int         GAP_CYCLES   = 500,
  parameter int         RESET_WAIT   = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        advance,
  output logic        sioc,
  output logic        siod_o,
  output logic        siod_oe,
  output logic        busy,
  output logic        config_done
);

  // The gap must cover the source's 2-cycle update latency after advance.
  localparam int         GAP_EFF  = max_int(GAP_CYCLES, 4);
  localparam int         WAIT_MAX = max_int(max_int(STARTUP_WAIT, GAP_EFF), RESET_WAIT);
  localparam int         WW       = $clog2(WAIT_MAX + 1);
  localparam logic [3:0] DC_POS   = 4'd8;

  sccb_state_t   r_state, w_state_next;
  logic [1:0]    r_q, w_q_next;          // quarter index within the phase
  logic [4:0]    r_bit, w_bit_next;      // 0..26 across the whole frame
  logic [3:0]    r_pos, w_pos_next;      // 0..8 within a byte phase
  logic [23:0]   r_shift, w_shift_next;  // current data bit is [23]
  logic          r_is_reset, w_is_reset_next;
  logic [WW-1:0] r_wait, w_wait_next;

  logic r_sioc, w_sioc_next;
  logic r_siod_o, w_siod_o_next;
  logic r_siod_oe, w_siod_oe_next;
  logic r_busy, w_busy_next;
  logic r_done, w_done_next;

  logic w_tick;
  logic w_restart;
  logic w_end;

  // Restarting in LOAD aligns the first quarter of START to a full period.
  assign w_restart = (r_state == LOAD);

  sccb_quarter_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // The end marker itself is also honoured in case finished ever lags it.
  assign w_end = finished || (command == END_CMD);

  // Next-state logic.
  always_comb begin
    w_state_next    = r_state;
    w_q_next        = r_q;
    w_bit_next      = r_bit;
    w_pos_next      = r_pos;
    w_shift_next    = r_shift;
    w_is_reset_next = r_is_reset;
    w_wait_next     = r_wait;

    unique case (r_state)
      WAIT: begin
        if (r_wait <= WW'(1)) begin
          w_state_next = LOAD;
        end else begin
          w_wait_next = r_wait - 1'b1;
        end
      end

      LOAD: begin
        if (w_end) begin
          w_state_next = DONE;
        end else begin
          w_shift_next    = {DEV_ADDR, command};
          w_is_reset_next = (command == SOFT_RESET_CMD);
          w_q_next        = 2'd0;
          w_state_next    = START;
        end
      end

      START: begin
        if (w_tick) begin
          if (r_q == 2'(START_Q - 1)) begin
            w_state_next = BIT;
            w_q_next     = 2'd0;
            w_bit_next   = 5'd0;
            w_pos_next   = 4'd0;
          end else begin
            w_q_next = r_q + 1'b1;
          end
        end
      end

      BIT: begin
        if (w_tick) begin
          if (r_q == 2'(BIT_Q - 1)) begin
            w_q_next = 2'd0;
            // The don't-care slot consumes no data bit.
            if (r_pos != DC_POS) begin
              w_shift_next = {r_shift[22:0], 1'b0};
            end
            w_pos_next = (r_pos == DC_POS) ? 4'd0 : r_pos + 1'b1;
            if (r_bit == 5'(SCCB_BITS - 1)) begin
              w_state_next = STOP;
            end else begin
              w_bit_next = r_bit + 1'b1;
            end
          end else begin
            w_q_next = r_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (w_tick) begin
          if (r_q == 2'(STOP_Q - 1)) begin
            w_state_next = WAIT;
            w_q_next     = 2'd0;
            w_wait_next  = r_is_reset ? WW'(RESET_WAIT) : WW'(GAP_EFF);
          end else begin
            w_q_next = r_q + 1'b1;
          end
        end
      end

      DONE: begin
      end

      default: begin
        w_state_next = WAIT;
        w_wait_next  = WW'(STARTUP_WAIT);
      end
    endcase
  end

  // Pin values are decoded from the next state and registered, so every
  // registered pin reflects the state held in the same cycle.
  always_comb begin
    w_sioc_next    = 1'b1;
    w_siod_o_next  = 1'b1;
    w_siod_oe_next = 1'b1;
    w_busy_next    = 1'b0;
    w_done_next    = 1'b0;

    unique case (w_state_next)
      START: begin
        w_busy_next   = 1'b1;
        w_siod_o_next = (w_q_next == 2'd0);
      end
      BIT: begin
        w_busy_next = 1'b1;
        w_sioc_next = w_q_next[1];
        if (w_pos_next == DC_POS) begin
          w_siod_oe_next = 1'b0;
        end else begin
          w_siod_o_next = w_shift_next[23];
        end
      end
      STOP: begin
        w_busy_next   = 1'b1;
        w_sioc_next   = (w_q_next != 2'd0);
        w_siod_o_next = (w_q_next == 2'd2);
      end
      DONE: begin
        w_done_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT;
      r_q        <= 2'd0;
      r_bit      <= 5'd0;
      r_pos      <= 4'd0;
      r_shift    <= 24'd0;
      r_is_reset <= 1'b0;
      r_wait     <= WW'(STARTUP_WAIT);
      r_sioc     <= 1'b1;
      r_siod_o   <= 1'b1;
      r_siod_oe  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_q        <= w_q_next;
      r_bit      <= w_bit_next;
      r_pos      <= w_pos_next;
      r_shift    <= w_shift_next;
      r_is_reset <= w_is_reset_next;
      r_wait     <= w_wait_next;
      r_sioc     <= w_sioc_next;
      r_siod_o   <= w_siod_o_next;
      r_siod_oe  <= w_siod_oe_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  // Last cycle of STOP; an AND of flop outputs, so exactly one cycle wide.
  assign advance     = (r_state == STOP) && (r_q == 2'(STOP_Q - 1)) && w_tick;
  assign sioc        = r_sioc;
  assign siod_o      = r_siod_o;
  assign siod_oe     = r_siod_oe;
  assign busy        = r_busy;
  assign config_done = r_done;

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// ---------------------------------------------------------------------------
// tb_ov7670_sccb_sender
// Drives the sender from a small command-source model (2-cycle update
// latency after advance), decodes the SCCB bus and checks frames, timing,
// advance pulses and bus protocol against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_ov7670_sccb_sender;

  localparam int TX_LEN = 113 * 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] command;
  logic        finished;
  logic        advance;
  logic        sioc;
  logic        siod_o;
  logic        siod_oe;
  logic        busy;
  logic        config_done;

  ov7670_sccb_sender #(
    .CLK_DIV      (4),
    .DEV_ADDR     (8'h42),
    .STARTUP_WAIT (20),
    .GAP_CYCLES   (10),
    .RESET_WAIT   (200)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .command     (command),
    .finished    (finished),
    .advance     (advance),
    .sioc        (sioc),
    .siod_o      (siod_o),
    .siod_oe     (siod_oe),
    .busy        (busy),
    .config_done (config_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- command source model ----------------
  logic [3:0][15:0] tb_rom;
  logic [1:0]       src_idx;
  logic             adv_d1;
  logic             cmd_ovr;
  logic [15:0]      ovr_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv_d1  <= 1'b0;
      src_idx <= 2'd0;
    end else begin
      adv_d1 <= advance;
      if (adv_d1 && (src_idx != 2'd3)) src_idx <= src_idx + 2'd1;
    end
  end

  assign command  = cmd_ovr ? ovr_val : tb_rom[src_idx];
  assign finished = (command == 16'hFFFF);

  // ---------------- bus monitor ----------------
  logic w_line;
  assign w_line = siod_oe ? siod_o : 1'b1;

  logic        mon_clr;
  logic [26:0] frames[$];
  logic [26:0] oes[$];
  int          edges_q[$];
  int          lens_q[$];
  int          gaps_q[$];
  int          adv_pulses, adv_maxw, adv_w, start_edges, stop_edges, rises;
  logic [27:0] cur_bits, cur_oe;
  int          cur_edges, cur_len, gap_cnt;
  bit          have_fall;
  logic        p_sioc, p_line, p_busy, p_adv, p_done;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        frames.delete(); oes.delete(); edges_q.delete(); lens_q.delete(); gaps_q.delete();
        adv_pulses = 0; adv_maxw = 0; adv_w = 0; start_edges = 0; stop_edges = 0; rises = 0;
        cur_bits = '0; cur_oe = '0; cur_edges = 0; cur_len = 0; gap_cnt = 0; have_fall = 0;
        p_sioc = 1'b1; p_line = 1'b1; p_busy = 1'b0; p_adv = 1'b0; p_done = 1'b0;
      end else if (!rst_n) begin
        cur_bits = '0; cur_oe = '0; cur_edges = 0; cur_len = 0; gap_cnt = 0; have_fall = 0;
        adv_w = 0;
        p_sioc = 1'b1; p_line = 1'b1; p_busy = 1'b0; p_adv = 1'b0; p_done = 1'b0;
      end else begin
        if (busy && !p_busy) begin
          if (have_fall) gaps_q.push_back(gap_cnt);
          have_fall = 0; cur_bits = '0; cur_oe = '0; cur_edges = 0; cur_len = 0;
        end
        if (config_done && !p_done && have_fall) begin
          gaps_q.push_back(gap_cnt);
          have_fall = 0;
        end
        if (p_sioc && sioc && (w_line != p_line)) begin
          if (w_line) stop_edges++;
          else        start_edges++;
        end
        if (!p_sioc && sioc) begin
          rises++;
          if (busy) begin
            cur_bits = {cur_bits[26:0], w_line};
            cur_oe   = {cur_oe[26:0], siod_oe};
            cur_edges++;
          end
        end
        if (busy) cur_len++;
        if (!busy && p_busy) begin
          // The final captured rise is the STOP clock, not a data bit.
          frames.push_back(cur_bits[27:1]);
          oes.push_back(cur_oe[27:1]);
          edges_q.push_back(cur_edges - 1);
          lens_q.push_back(cur_len);
          $display("tx: frame=%07h oe=%07h data_edges=%0d len=%0d", cur_bits[27:1],
                   cur_oe[27:1], cur_edges - 1, cur_len);
          have_fall = 1; gap_cnt = 0;
        end
        if (!busy && have_fall) gap_cnt++;
        if (advance) adv_w++;
        else if (p_adv) begin
          adv_pulses++;
          if (adv_w > adv_maxw) adv_maxw = adv_w;
          adv_w = 0;
        end
        p_sioc = sioc; p_line = w_line; p_busy = busy; p_adv = advance; p_done = config_done;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int vectors;
  int miscompares;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input int act, input int lo);
    vectors++;
    if (act < lo) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected >= %0d", nm, act, lo);
    end
  endtask

  function automatic logic [26:0] mk_frame(input logic [23:0] d);
    return {d[23:16], 1'b1, d[15:8], 1'b1, d[7:0], 1'b1};
  endfunction

  localparam logic [26:0] OE_EXP = {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};

  task automatic clear_mon();
    mon_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (config_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_busy(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic start_run(input logic [3:0][15:0] rom);
    rst_n   = 1'b0;
    cmd_ovr = 1'b0;
    ovr_val = 16'h0000;
    tb_rom  = rom;
    clear_mon();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0][15:0] rom;
    int               exp_tx;
    logic [1:0][23:0] exp_data;
    int               n_gaps;
    int               gap_min0;
    int               gap_min1;
  } vec_t;

  localparam int NV = 4;
  vec_t vecs[NV];

  initial begin
    bit ok;

    vectors     = 0;
    miscompares = 0;
    mon_clr     = 1'b0;
    rst_n       = 1'b0;
    cmd_ovr     = 1'b0;
    ovr_val     = 16'h0000;
    tb_rom      = {4{16'hFFFF}};

    vecs[0].rom = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3A14};
    vecs[0].exp_tx = 1; vecs[0].exp_data = {24'h0, 24'h423A14};
    vecs[0].n_gaps = 1; vecs[0].gap_min0 = 10; vecs[0].gap_min1 = 0;

    vecs[1].rom = {16'hFFFF, 16'hFFFF, 16'h1200, 16'h1280};
    vecs[1].exp_tx = 2; vecs[1].exp_data = {24'h421200, 24'h421280};
    vecs[1].n_gaps = 2; vecs[1].gap_min0 = 200; vecs[1].gap_min1 = 10;

    vecs[2].rom = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[2].exp_tx = 0; vecs[2].exp_data = {24'h0, 24'h0};
    vecs[2].n_gaps = 0; vecs[2].gap_min0 = 0; vecs[2].gap_min1 = 0;

    vecs[3].rom = {16'hFFFF, 16'hAA7E, 16'h0155, 16'hFF00};
    vecs[3].exp_tx = 3; vecs[3].exp_data = {24'h420155, 24'h42FF00};
    vecs[3].n_gaps = 3; vecs[3].gap_min0 = 10; vecs[3].gap_min1 = 10;

    for (int s = 0; s < NV; s++) begin
      rst_n   = 1'b0;
      cmd_ovr = 1'b0;
      tb_rom  = vecs[s].rom;
      clear_mon();
      chk($sformatf("v%0d_reset_pins", s),
          32'({advance, sioc, siod_o, siod_oe, busy, config_done}), 32'b011100);
      @(negedge clk);
      rst_n = 1'b1;
      wait_done(4000, ok);
      chk($sformatf("v%0d_done_reached", s), 32'(ok), 32'd1);
      repeat (5) @(negedge clk);

      chk($sformatf("v%0d_tx_count", s), 32'(frames.size()), 32'(vecs[s].exp_tx));
      chk($sformatf("v%0d_adv_pulses", s), 32'(adv_pulses), 32'(vecs[s].exp_tx));
      chk($sformatf("v%0d_adv_width", s), 32'(adv_maxw), (vecs[s].exp_tx > 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_start_edges", s), 32'(start_edges), 32'(vecs[s].exp_tx));
      chk($sformatf("v%0d_stop_edges", s), 32'(stop_edges), 32'(vecs[s].exp_tx));
      chk($sformatf("v%0d_sioc_rises", s), 32'(rises), 32'(28 * vecs[s].exp_tx));
      chk($sformatf("v%0d_idle_pins", s),
          32'({advance, sioc, siod_o, siod_oe, busy, config_done}), 32'b011101);
      for (int i = 0; i < frames.size(); i++) begin
        chk($sformatf("v%0d_tx%0d_len", s, i), 32'(lens_q[i]), 32'(TX_LEN));
        chk($sformatf("v%0d_tx%0d_edges", s, i), 32'(edges_q[i]), 32'd27);
        chk($sformatf("v%0d_tx%0d_oe", s, i), 32'(oes[i]), 32'(OE_EXP));
        if (i < 2)
          chk($sformatf("v%0d_tx%0d_frame", s, i), 32'(frames[i]),
              32'(mk_frame(vecs[s].exp_data[i])));
      end
      chk($sformatf("v%0d_gap_count", s), 32'(gaps_q.size()), 32'(vecs[s].n_gaps));
      if (gaps_q.size() > 0) chk_ge($sformatf("v%0d_gap0", s), gaps_q[0], vecs[s].gap_min0);
      if (gaps_q.size() > 1) chk_ge($sformatf("v%0d_gap1", s), gaps_q[1], vecs[s].gap_min1);
    end

    // finished at the very first LOAD: config_done timing
    start_run({4{16'hFFFF}});
    repeat (20) @(posedge clk);
    #1 chk("first_load_done_early", 32'(config_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("first_load_done_at_sw2", 32'(config_done), 32'd1);
    repeat (10) @(negedge clk);
    chk("first_load_no_edges", 32'(rises), 32'd0);
    chk("first_load_no_advance", 32'(adv_pulses), 32'd0);

    // reset mid-BIT, then entry 0 must be resent
    start_run({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1280});
    wait_busy(200, ok);
    chk("rstmid_busy_seen", 32'(ok), 32'd1);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8 && sioc; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rstmid_immediate", 32'({sioc, siod_o, busy, advance}), 32'b1100);
    @(negedge clk);
    chk("rstmid_next_cycle", 32'({sioc, siod_o, siod_oe, busy, advance}), 32'b11100);
    clear_mon();
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(4000, ok);
    chk("rstmid_done_reached", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    chk("rstmid_tx_count", 32'(frames.size()), 32'd1);
    if (frames.size() > 0)
      chk("rstmid_frame", 32'(frames[0]), 32'(mk_frame(24'h421280)));
    chk("rstmid_adv_pulses", 32'(adv_pulses), 32'd1);

    // command changes mid-transaction must not disturb the frame
    start_run({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3A14});
    wait_busy(200, ok);
    chk("ovr_busy_seen", 32'(ok), 32'd1);
    repeat (100) @(negedge clk);
    ovr_val = 16'h5555;
    cmd_ovr = 1'b1;
    repeat (200) @(negedge clk);
    cmd_ovr = 1'b0;
    wait_done(4000, ok);
    chk("ovr_done_reached", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    chk("ovr_tx_count", 32'(frames.size()), 32'd1);
    if (frames.size() > 0)
      chk("ovr_frame", 32'(frames[0]), 32'(mk_frame(24'h423A14)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
